// File: rtl/decode_stage_hz.sv
// ID stage with built-in ID/EX register: decodes one instruction per cycle and inserts
// its own bubbles for load-use and multiply-latency hazards, honouring downstream stall/flush.
module decode_stage_hz #(
    parameter int ADDR_W   = 32,
    parameter int REG_SIZE = 32,
    parameter int REG_ADDR = 5,
    parameter int MUL_LAT  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [31:0]         instruction,
    input  logic                stall,
    input  logic                flush,
    output logic [REG_ADDR-1:0] src_reg1,
    output logic [REG_ADDR-1:0] src_reg2,
    input  logic [REG_SIZE-1:0] rin_reg1,
    input  logic [REG_SIZE-1:0] rin_reg2,
    output logic                stall_out,
    output logic [ADDR_W-1:0]   jump_addr,
    output logic                is_jump,
    output logic                out_valid,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [ADDR_W-1:0]   out_imm,
    output logic [REG_ADDR-1:0] out_addr_reg1,
    output logic [REG_ADDR-1:0] out_addr_reg2,
    output logic [REG_SIZE-1:0] rout_reg1,
    output logic [REG_SIZE-1:0] rout_reg2,
    output logic [REG_ADDR-1:0] dest_reg,
    output logic [5:0]          op_code,
    output logic [5:0]          funct_code,
    output logic                regwrite,
    output logic                memtoreg,
    output logic                memread,
    output logic                memwrite,
    output logic                byteword,
    output logic                alusrc,
    output logic                branch,
    output logic                is_mult
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_JUMP = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LDB = 6'h20, OP_LDW = 6'h23, OP_STB = 6'h28, OP_STW = 6'h2B;
    localparam logic [5:0] FN_MUL = 6'h18;
    localparam int CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
    localparam logic [ADDR_W-1:0] JMASK = {4'hF, {(ADDR_W-4){1'b0}}};

    // control vector order: regwrite,memtoreg,memread,memwrite,byteword,alusrc,branch,is_mult
    logic [7:0]          ctrl_q, ctrl_d, dec_ctrl;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   pc_q, pc_d, imm_q, imm_d;
    logic [REG_ADDR-1:0] ra1_q, ra1_d, ra2_q, ra2_d, dest_q, dest_d, dec_dest;
    logic [REG_SIZE-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic [5:0]          op_q, op_d, fn_q, fn_d;
    logic [CNT_W-1:0]    mul_cnt_q, mul_cnt_d;
    logic [REG_ADDR-1:0] mul_dest_q, mul_dest_d;

    logic [5:0]          opcode, funct;
    logic [REG_ADDR-1:0] rs, rt, rd;
    logic                use_rs, use_rt, ld_hz, mul_hz, hazard;

    assign opcode   = instruction[31:26];
    assign funct    = instruction[5:0];
    assign rs       = REG_ADDR'(instruction[25:21]);
    assign rt       = REG_ADDR'(instruction[20:16]);
    assign rd       = REG_ADDR'(instruction[15:11]);
    assign src_reg1 = rs;
    assign src_reg2 = rt;

    always_comb begin
        dec_ctrl = 8'b0;
        dec_dest = '0;
        use_rt   = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                dec_ctrl = {7'b1000000, funct == FN_MUL};
                dec_dest = rd;
                use_rt   = 1'b1;
            end
            OP_ADDI: begin dec_ctrl = 8'b10000100; dec_dest = rt; end
            OP_LDW:  begin dec_ctrl = 8'b11101100; dec_dest = rt; end
            OP_LDB:  begin dec_ctrl = 8'b11100100; dec_dest = rt; end
            OP_STW:  begin dec_ctrl = 8'b00011100; use_rt = 1'b1; end
            OP_STB:  begin dec_ctrl = 8'b00010100; use_rt = 1'b1; end
            OP_BEQ:  begin dec_ctrl = 8'b00000010; use_rt = 1'b1; end
            default: ;
        endcase
    end

    // register 0 is hardwired, so a match against it is never a real dependency
    assign use_rs = (opcode != OP_JUMP);
    assign ld_hz  = valid_q && ctrl_q[5] && (dest_q != '0) &&
                    ((use_rs && rs == dest_q) || (use_rt && rt == dest_q));
    assign mul_hz = (mul_cnt_q != '0) && (mul_dest_q != '0) &&
                    ((use_rs && rs == mul_dest_q) || (use_rt && rt == mul_dest_q));
    assign hazard = in_valid && (ld_hz || mul_hz);

    assign stall_out = stall || (hazard && !flush);
    assign jump_addr = (pc & JMASK) | ADDR_W'({instruction[25:0], 2'b00});
    assign is_jump   = (opcode == OP_JUMP) && in_valid && !stall_out && !flush;

    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        ra1_d      = ra1_q;
        ra2_d      = ra2_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        dest_d     = dest_q;
        op_d       = op_q;
        fn_d       = fn_q;
        mul_dest_d = mul_dest_q;
        mul_cnt_d  = mul_cnt_q;
        // the multiply already in EX keeps ageing even when ID is flushed
        if (!stall && mul_cnt_q != '0)
            mul_cnt_d = mul_cnt_q - CNT_W'(1);
        if (flush || (!stall && (hazard || !in_valid))) begin
            valid_d = 1'b0;
            ctrl_d  = 8'b0;
            dest_d  = '0;
        end else if (!stall) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            pc_d    = pc;
            imm_d   = {{(ADDR_W-16){instruction[15]}}, instruction[15:0]};
            ra1_d   = rs;
            ra2_d   = rt;
            rd1_d   = rin_reg1;
            rd2_d   = rin_reg2;
            dest_d  = dec_dest;
            op_d    = opcode;
            fn_d    = funct;
            if (dec_ctrl[0] && MUL_LAT != 0) begin
                mul_dest_d = dec_dest;
                mul_cnt_d  = CNT_W'(MUL_LAT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            ctrl_q     <= 8'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            ra1_q      <= '0;
            ra2_q      <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            dest_q     <= '0;
            op_q       <= '0;
            fn_q       <= '0;
            mul_dest_q <= '0;
            mul_cnt_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            ra1_q      <= ra1_d;
            ra2_q      <= ra2_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            dest_q     <= dest_d;
            op_q       <= op_d;
            fn_q       <= fn_d;
            mul_dest_q <= mul_dest_d;
            mul_cnt_q  <= mul_cnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_imm       = imm_q;
    assign out_addr_reg1 = ra1_q;
    assign out_addr_reg2 = ra2_q;
    assign rout_reg1     = rd1_q;
    assign rout_reg2     = rd2_q;
    assign dest_reg      = dest_q;
    assign op_code       = op_q;
    assign funct_code    = fn_q;
    assign {regwrite, memtoreg, memread, memwrite, byteword, alusrc, branch, is_mult} = ctrl_q;
endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
Parametrised ID stage with an integrated ID/EX boundary register. It decodes one instruction per cycle and reads operands through an external register bank. It generates control signals internally and detects load-use and multiply-latency hazards against in-flight instructions, inserting bubbles itself. It also handles downstream stall and flush, so the pipeline no longer relies on a separate hazard unit.

Parameters:
ADDR_W, 32, PC/address and immediate width
REG_SIZE, 32, register data width
REG_ADDR, 5, register address width (instr fields fixed at 5 bits; upper bits zero-padded)
MUL_LAT, 4, cycles a multiply result is unavailable after leaving ID (0 disables multiply tracking)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  IF/ID holds a real instruction
pc  in  ADDR_W  PC of instruction
instruction  in  32  instruction word
stall  in  1  downstream busy: hold ID/EX contents
flush  in  1  taken branch/redirect: kill ID contents
src_reg1 / src_reg2  out  REG_ADDR  regfile read addresses = instr[25:21] / instr[20:16] (combinational)
rin_reg1 / rin_reg2  in  REG_SIZE  regfile read data
stall_out  out  1  to IF: hold PC and IF/ID (combinational)
jump_addr  out  ADDR_W  (pc & top-4-bit mask) | (instr[25:0]<<2) (combinational)
is_jump  out  1  opcode==JUMP & in_valid & ~stall_out & ~flush (combinational)
out_valid  out  1  ID/EX holds real instruction
out_pc, out_imm  out  ADDR_W  bypassed PC; sign-extended instr[15:0] to full ADDR_W
out_addr_reg1/2  out  REG_ADDR  registered read addresses (forwarding)
rout_reg1/2  out  REG_SIZE  registered operands
dest_reg  out  REG_ADDR  write-back register
op_code, funct_code  out  6  registered fields
regwrite, memtoreg, memread, memwrite, byteword, alusrc, branch, is_mult  out  1  registered controls

Behaviour:
- Opcodes: RTYPE 6'h00 (FN_MUL 6'h18), JUMP 6'h02, BEQ 6'h04, ADDI 6'h08, LDB 6'h20, LDW 6'h23, STB 6'h28, STW 6'h2B. Any other opcode decodes as NOP: all controls 0, out_valid still 1.
- Control table:
  - RTYPE: regwrite; dest = [15:11]; is_mult = (funct==FN_MUL).
  - ADDI: regwrite, alusrc; dest = [20:16].
  - LDW: regwrite, memtoreg, memread, alusrc, byteword = 1; dest = [20:16].
  - LDB: as LDW but byteword = 0.
  - STW: memwrite, alusrc, byteword = 1; dest = 0.
  - STB: as STW but byteword = 0.
  - BEQ: branch; dest = 0.
  - JUMP: all registered controls 0.
- Source use: rs is used by every opcode except JUMP. rt is used by RTYPE, BEQ, STB, STW. A source equal to register 0 never causes a hazard.
- Load-use hazard: out_valid & memread & dest_reg matches a used source of the current in_valid instruction.
- Multiply hazard:
  - When an instruction with is_mult leaves ID (registered with out_valid & ~stall), load mul_dest and set mul_cnt = MUL_LAT.
  - mul_cnt decrements each cycle it is nonzero while stall is low.
  - Hazard while mul_cnt != 0 & used source == mul_dest (mul_dest != 0).
  - A new multiply reloads both mul_dest and mul_cnt.
- stall_out = stall | (hazard & ~flush).
- Each posedge, in priority order:
  1. reset: out_valid = 0, all controls 0, every data output 0, mul_cnt = 0, mul_dest = 0.
  2. flush: out_valid = 0, controls 0; data outputs don't-care; mul_cnt continues counting.
  3. stall: hold all outputs and mul_cnt.
  4. hazard or ~in_valid: bubble (out_valid = 0, controls 0).
  5. else: register the decoded instruction, out_valid = 1.
- All registered controls are forced to 0 whenever out_valid = 0, so they are safe for EX/MEM/WB without further gating.
- Latency: one cycle from IF/ID to ID/EX. A load-use hazard costs exactly 1 bubble. A multiply consumer issued immediately after the multiply costs MUL_LAT bubbles.
- Reset mid-hazard clears mul tracking. The first instruction after reset is never stalled.

Test Plan:
- Reset then LDW r2,0(r1) (0x8C220000) followed by ADD r3,r2,r4 -> cycle1 out_valid=1, memread=1, dest_reg=2; ADD sees stall_out=1 for 1 cycle, 1 bubble (out_valid=0, regwrite=0), then ADD issues with dest_reg=3, regwrite=1.
- MUL r5,r6,r7 then ADD r8,r5,r0, MUL_LAT=4 -> 4 bubble cycles, ADD issues on 5th cycle after MUL. Same test with ADD r8,r9,r0 -> no bubble.
- STB r2,4(r1) -> memwrite=1, byteword=0, regwrite=0, dest_reg=0, out_imm=4. ADDI with imm 0xFFFC -> out_imm=32'hFFFFFFFC.
- JUMP 0x0000010 at pc=32'h4000_0000 -> is_jump=1, jump_addr=32'h4000_0040; next cycle all registered controls 0.
- stall held 3 cycles mid-stream -> ID/EX outputs unchanged all 3 cycles, stall_out=1. flush asserted together with stall and a load-use hazard -> out_valid=0 next edge, stall_out follows stall only.
- reset asserted while mul_cnt=2 -> next cycle all outputs 0, mul_cnt=0, a dependent ADD issues without bubble.
